ins_hazard_window: RTL and testbench

- Parametrised successor to the combinational instruction classifier: registered decode-stage analyser with a DEPTH-entry in-flight window (scoreboard).
- Classifies each incoming IR, extracts source/destination registers, detects RAW hazards against older in-flight instructions, emits forwarding selects, and stalls on load-use.
- Sits between fetch and the execute pipeline; counts stalls and issued instructions.

---
 rtl/ins_hazard_window.sv | 149 ++++++++++++++
 tb/tb_ins_hazard_window.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_hazard_window.sv
// Registered decode-stage analyser: classifies instructions, tracks a DEPTH-entry
// in-flight window for RAW forwarding, and stalls on load-use.
module ins_hazard_window #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [31:0]                    in_ir,
  output logic                           in_ready,
  input  logic                           flush,
  output logic                           out_valid,
  output logic [5:0]                     out_class,
  output logic [4:0]                     out_rs,
  output logic [4:0]                     out_rt,
  output logic [4:0]                     out_dst,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_b,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               instr_cnt
);

  localparam int unsigned FW = $clog2(DEPTH+1);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  assign opcode = in_ir[31:26];
  assign rs     = in_ir[25:21];
  assign rt     = in_ir[20:16];
  assign rd     = in_ir[15:11];
  assign funct  = in_ir[5:0];

  logic [5:0] cls;
  logic [4:0] dst;
  logic       use_rs, use_rt, is_load;

  // Class bits: [5] nop, [4] alu_imm, [3] alu_r, [2] store, [1] load, [0] branch.
  always_comb begin
    cls     = '0;
    dst     = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_load = 1'b0;
    unique case (opcode)
      6'b000100, 6'b000101: begin
        cls[0] = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'b100011: begin
        cls[1]  = 1'b1;
        dst     = rt;
        use_rs  = 1'b1;
        is_load = 1'b1;
      end
      6'b101011: begin
        cls[2] = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'b000000: begin
        if (funct != '0) begin
          cls[3] = 1'b1;
          dst    = rd;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
      end
      6'b001000, 6'b001100, 6'b001110, 6'b001011: begin
        cls[4] = 1'b1;
        dst    = rt;
        use_rs = 1'b1;
      end
      6'b111111: cls[5] = 1'b1;
      default: ;
    endcase
  end

  logic [DEPTH-1:0] win_v, win_ld;
  logic [4:0]       win_dst [DEPTH];

  logic [FW-1:0] dist_a, dist_b;
  logic          found_a, found_b, ld_a, ld_b, hazard, accept;

  // Youngest-first search: the first hit per source governs both forwarding and stall.
  always_comb begin
    dist_a  = '0;
    dist_b  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found_a && win_v[k] && win_dst[k] != '0 && win_dst[k] == rs) begin
        found_a = 1'b1;
        dist_a  = FW'(k + 1);
        ld_a    = win_ld[k] && (k < LOAD_STALL);
      end
      if (!found_b && win_v[k] && win_dst[k] != '0 && win_dst[k] == rt) begin
        found_b = 1'b1;
        dist_b  = FW'(k + 1);
        ld_b    = win_ld[k] && (k < LOAD_STALL);
      end
    end
    hazard = (use_rs && ld_a) || (use_rt && ld_b);
  end

  assign in_ready = !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_v     <= '0;
      win_ld    <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) win_dst[k] <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_dst   <= '0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (flush) win_v <= '0;
      else       win_v <= {win_v[DEPTH-2:0], accept};
      win_ld <= {win_ld[DEPTH-2:0], is_load};
      for (int unsigned k = 1; k < DEPTH; k++) win_dst[k] <= win_dst[k-1];
      win_dst[0] <= dst;

      out_valid <= accept;
      if (accept) begin
        out_class <= cls;
        out_rs    <= rs;
        out_rt    <= rt;
        out_dst   <= dst;
        fwd_a     <= use_rs ? dist_a : '0;
        fwd_b     <= use_rt ? dist_b : '0;
        if (instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
      end
      if (in_valid && hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ins_hazard_window.sv
// Self-checking bench for ins_hazard_window: queue-based reference model plus
// directed literal checks, then randomized traffic with flushes and resets.
module tb_ins_hazard_window;

  localparam int DEPTH = 3;
  localparam int LS    = 1;
  localparam int FW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, flush;
  logic [31:0]   in_ir;
  logic          in_ready, out_valid;
  logic [5:0]    out_class;
  logic [4:0]    out_rs, out_rt, out_dst;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [31:0]   stall_cnt, instr_cnt;

  logic          s_in_ready, s_out_valid;
  logic [5:0]    s_out_class;
  logic [4:0]    s_out_rs, s_out_rt, s_out_dst;
  logic [FW-1:0] s_fwd_a, s_fwd_b;
  logic [2:0]    s_stall_cnt, s_instr_cnt;

  ins_hazard_window #(.DEPTH(DEPTH), .LOAD_STALL(LS), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ir(in_ir),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_class(out_class), .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .instr_cnt(instr_cnt));

  ins_hazard_window #(.DEPTH(DEPTH), .LOAD_STALL(LS), .CNT_W(3)) sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ir(in_ir),
    .in_ready(s_in_ready), .flush(flush), .out_valid(s_out_valid),
    .out_class(s_out_class), .out_rs(s_out_rs), .out_rt(s_out_rt), .out_dst(s_out_dst),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .instr_cnt(s_instr_cnt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit v; int dst; bit ld; } ent_t;
  ent_t win[$];

  bit      m_valid;
  bit [5:0] m_class;
  int      m_rs, m_rt, m_dst, m_fa, m_fb;
  longint  m_stall, m_instr;
  bit      armed = 0;

  function automatic void decode(input logic [31:0] ir, output bit [5:0] c,
                                 output int d, output bit ur, output bit ut, output bit ld);
    int op = int'(ir[31:26]);
    c = '0; d = 0; ur = 0; ut = 0; ld = 0;
    if (op == 4 || op == 5)            begin c = 6'b000001; ur = 1; ut = 1; end
    else if (op == 35)                 begin c = 6'b000010; d = int'(ir[20:16]); ur = 1; ld = 1; end
    else if (op == 43)                 begin c = 6'b000100; ur = 1; ut = 1; end
    else if (op == 0 && ir[5:0] != 0)  begin c = 6'b001000; d = int'(ir[15:11]); ur = 1; ut = 1; end
    else if (op == 8 || op == 12 || op == 14 || op == 11)
                                       begin c = 6'b010000; d = int'(ir[20:16]); ur = 1; end
    else if (op == 63)                 c = 6'b100000;
  endfunction

  // Index of the youngest window entry writing s, or -1.
  function automatic int gov(input int s);
    if (s == 0) return -1;
    for (int k = 0; k < win.size(); k++)
      if (win[k].v && win[k].dst == s) return k;
    return -1;
  endfunction

  function automatic bit m_hazard(input logic [31:0] ir);
    bit [5:0] c; int d; bit ur, ut, ld; int ka, kb;
    decode(ir, c, d, ur, ut, ld);
    ka = ur ? gov(int'(ir[25:21])) : -1;
    kb = ut ? gov(int'(ir[20:16])) : -1;
    return (ka >= 0 && win[ka].ld && ka < LS) || (kb >= 0 && win[kb].ld && kb < LS);
  endfunction

  function automatic void model_reset();
    win.delete();
    for (int k = 0; k < DEPTH; k++) win.push_back('{0, 0, 0});
    m_valid = 0; m_class = '0; m_rs = 0; m_rt = 0; m_dst = 0; m_fa = 0; m_fb = 0;
    m_stall = 0; m_instr = 0;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      bit [5:0] c; int d; bit ur, ut, ld, hz, acc;
      decode(in_ir, c, d, ur, ut, ld);
      hz  = m_hazard(in_ir);
      acc = in_valid && !hz && !flush;
      if (acc) begin
        m_class = c; m_rs = int'(in_ir[25:21]); m_rt = int'(in_ir[20:16]); m_dst = d;
        m_fa = (ur ? gov(m_rs) : -1) + 1;
        m_fb = (ut ? gov(m_rt) : -1) + 1;
        m_instr++;
      end
      if (in_valid && hz && !flush) m_stall++;
      m_valid = acc;
      win.push_front('{acc, d, ld});
      void'(win.pop_back());
      if (flush) foreach (win[k]) win[k].v = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",    in_ready,    !m_hazard(in_ir) && !flush);
      chk("s_in_ready",  s_in_ready,  !m_hazard(in_ir) && !flush);
      chk("out_valid",   out_valid,   m_valid);
      chk("out_class",   out_class,   m_class);
      chk("out_rs",      out_rs,      m_rs);
      chk("out_rt",      out_rt,      m_rt);
      chk("out_dst",     out_dst,     m_dst);
      chk("fwd_a",       fwd_a,       m_fa);
      chk("fwd_b",       fwd_b,       m_fb);
      chk("stall_cnt",   stall_cnt,   m_stall);
      chk("instr_cnt",   instr_cnt,   m_instr);
      chk("sat_stall",   s_stall_cnt, (m_stall > 7) ? 7 : m_stall);
      chk("sat_instr",   s_instr_cnt, (m_instr > 7) ? 7 : m_instr);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADDI1 = 32'h20010005;  // addi $1,$0,5
  localparam logic [31:0] ADD3  = 32'h00221820;  // add  $3,$1,$2
  localparam logic [31:0] SUB4  = 32'h00632022;  // sub  $4,$3,$3
  localparam logic [31:0] NOP   = 32'hFC000000;
  localparam logic [31:0] LW5   = 32'h8C250000;  // lw   $5,0($1)
  localparam logic [31:0] ADD6  = 32'h00A03020;  // add  $6,$5,$0
  localparam logic [31:0] ADDI7A= 32'h20070001;
  localparam logic [31:0] ADDI7B= 32'h20070002;
  localparam logic [31:0] ADD8  = 32'h00E74020;  // add  $8,$7,$7
  localparam logic [31:0] ADDI0 = 32'h20000003;  // addi $0,$0,3
  localparam logic [31:0] ADD9  = 32'h00004820;  // add  $9,$0,$0

  task automatic drive(input bit v, input logic [31:0] ir, input bit f);
    in_valid = v; in_ir = ir; flush = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [5:0] ops [12];
    logic [5:0] op, fn;
    ops = '{6'd4, 6'd5, 6'd35, 6'd43, 6'd0, 6'd0, 6'd8, 6'd12, 6'd14, 6'd11, 6'd63, 6'd17};
    op = ops[$urandom_range(0, 11)];
    fn = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'(32 + $urandom_range(0, 7));
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'd0, fn};
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; in_ir = '0; flush = 0;
    tick();
    armed = 1;
    tick();
    rst_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", instr_cnt, 0);
    chk("rst_stall", stall_cnt, 0);

    drive(1, ADDI1, 0);
    chk("addi_ready", in_ready, 1);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_class", out_class, 6'b010000);
    chk("addi_dst", out_dst, 1);
    chk("addi_fwd_a", fwd_a, 0);
    chk("addi_instr", instr_cnt, 1);

    drive(1, ADD3, 0); tick();
    drive(1, SUB4, 0); tick();
    chk("b2b_fwd_a", fwd_a, 1);
    chk("b2b_fwd_b", fwd_b, 1);
    chk("b2b_stall", stall_cnt, 0);

    drive(1, ADD3, 0); tick();
    drive(1, NOP, 0);  tick();
    drive(1, SUB4, 0); tick();
    chk("gap_fwd_a", fwd_a, 2);
    chk("gap_fwd_b", fwd_b, 2);

    drive(1, LW5, 0); tick();
    drive(1, ADD6, 0);
    chk("lu_ready_lo", in_ready, 0);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_stall", stall_cnt, 1);
    chk("lu_ready_hi", in_ready, 1);
    tick();
    chk("lu_valid", out_valid, 1);
    chk("lu_fwd_a", fwd_a, 2);
    chk("lu_fwd_b", fwd_b, 0);
    chk("lu_stall2", stall_cnt, 1);

    drive(1, ADDI7A, 0); tick();
    drive(1, ADDI7B, 0); tick();
    drive(1, ADD8, 0);   tick();
    chk("young_fwd_a", fwd_a, 1);
    chk("young_fwd_b", fwd_b, 1);
    drive(1, ADDI0, 0); tick();
    chk("r0_dst", out_dst, 0);
    drive(1, ADD9, 0);
    chk("r0_ready", in_ready, 1);
    tick();
    chk("r0_fwd_a", fwd_a, 0);
    chk("r0_fwd_b", fwd_b, 0);

    drive(1, LW5, 0); tick();
    drive(1, ADD6, 0);
    chk("fl_stall_ready", in_ready, 0);
    tick();
    drive(1, ADD6, 1);
    chk("fl_ready", in_ready, 0);
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_stall", stall_cnt, 2);
    drive(1, ADD6, 0);
    chk("fl_after_ready", in_ready, 1);
    tick();
    chk("fl_acc_valid", out_valid, 1);
    chk("fl_fwd_a", fwd_a, 0);
    chk("fl_stall2", stall_cnt, 2);

    drive(1, LW5, 0); tick();
    drive(1, ADD6, 0);
    chk("mr_ready_lo", in_ready, 0);
    rst_n = 0;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_class", out_class, 0);
    chk("mr_rs", out_rs, 0);
    chk("mr_rt", out_rt, 0);
    chk("mr_dst", out_dst, 0);
    chk("mr_fwd", {fwd_a, fwd_b}, 0);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_instr", instr_cnt, 0);
    chk("mr_ready", in_ready, 1);
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      drive(1, LW5, 0);  tick();
      drive(1, ADD6, 0); tick();
      drive(0, NOP, 0);  tick();
    end
    chk("sat_stall_full", stall_cnt, 9);
    chk("sat_stall_pin", s_stall_cnt, 7);
    chk("sat_instr_pin", s_instr_cnt, 7);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 3) != 0, rand_ir(), $urandom_range(0, 15) == 0);
      tick();
    end

    rst_n = 1;
    drive(0, NOP, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
